// File: rtl/multicycle_control.sv
// Main control FSM of the multi-cycle MIPS datapath: fetch/decode/execute/memory/writeback
// sequencing, datapath strobes and mux selects, and a memory-ready watchdog.
module multicycle_control #(
  parameter int MEM_WAIT_MAX = 15,
  parameter int CNT_W        = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       pc_en,
  output logic [1:0] pc_src,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic       illegal_op,
  output logic       mem_timeout,
  output logic [3:0] state_out
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_I_EXEC   = 4'd10,
    S_I_WB     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MEM_WAIT_MAX);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             mem_timeout_q, mem_timeout_d;
  logic             illegal_op_q, illegal_op_d;
  logic [2:0]       iop_q, iop_d;

  logic             in_wait;
  logic             wait_expired;
  logic             op_known;
  logic [2:0]       iop_dec;

  // Opcode classification; iop_dec is the ALU code used later by I_EXEC.
  always_comb begin
    iop_dec  = 3'b000;
    op_known = 1'b1;
    case (opcode)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: iop_dec = 3'b000;
      OP_ANDI: iop_dec = 3'b110;
      OP_ORI:  iop_dec = 3'b010;
      OP_SLTI: iop_dec = 3'b111;
      default: op_known = 1'b0;
    endcase
  end

  assign in_wait      = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
  assign wait_expired = in_wait && !mem_ready && (wait_cnt_q == WAIT_LIMIT);

  // Counter is zero whenever a wait state is (re)entered, including a FETCH retry after timeout.
  always_comb begin
    wait_cnt_d    = '0;
    if (in_wait && !mem_ready && !wait_expired) begin
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
    end
    mem_timeout_d = mem_timeout_q | wait_expired;
    illegal_op_d  = (state_q == S_DECODE) && !op_known;
    iop_d         = (state_q == S_DECODE) ? iop_dec : iop_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_FETCH;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
      illegal_op_q  <= 1'b0;
      iop_q         <= 3'b000;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
      illegal_op_q  <= illegal_op_d;
      iop_q         <= iop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (mem_ready) state_d = S_DECODE;
        else           state_d = S_FETCH;
      end
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:                          state_d = S_R_EXEC;
          OP_LW, OP_SW:                      state_d = S_MEM_ADDR;
          OP_BEQ:                            state_d = S_BRANCH;
          OP_J:                              state_d = S_JUMP;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_I_EXEC;
          default:                           state_d = S_FETCH;
        endcase
      end
      S_MEM_ADDR: state_d = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: begin
        if (mem_ready)         state_d = S_MEM_WB;
        else if (wait_expired) state_d = S_FETCH;
      end
      S_MEM_WB: state_d = S_FETCH;
      S_MEM_WR: begin
        if (mem_ready || wait_expired) state_d = S_FETCH;
      end
      S_R_EXEC: state_d = S_R_WB;
      S_R_WB:   state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      S_I_EXEC: state_d = S_I_WB;
      S_I_WB:   state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  // Moore decode, except the FETCH PC/IR loads which follow mem_ready directly.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_src        = 2'b00;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 3'b000;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        pc_write  = mem_ready;
        ir_write  = mem_ready;
      end
      S_DECODE: alu_src_b = 2'b11;
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 3'b100;
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 3'b001;
        pc_write_cond = 1'b1;
        pc_src        = 2'b01;
      end
      S_JUMP: begin
        pc_write = 1'b1;
        pc_src   = 2'b10;
      end
      S_I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = iop_q;
      end
      S_I_WB: reg_write = 1'b1;
      default: ;
    endcase

    if (rst) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      pc_src        = 2'b00;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      alu_op        = 3'b000;
    end

    pc_en = pc_write | (pc_write_cond & zero);
  end

  assign illegal_op  = illegal_op_q & ~rst;
  assign mem_timeout = mem_timeout_q & ~rst;
  assign state_out   = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class through its states
// and checks strobes, selects, stalls, the watchdog and reset against hand-derived values.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, pc_en, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op, mem_timeout;
  logic [1:0] pc_src, alu_src_b;
  logic [2:0] alu_op;
  logic [3:0] state_out;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI = 6'b001101, OP_SLTI = 6'b001010, OP_BAD = 6'b111111;

  multicycle_control #(.MEM_WAIT_MAX(15), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_en(pc_en), .pc_src(pc_src),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .illegal_op(illegal_op), .mem_timeout(mem_timeout), .state_out(state_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock edge, then apply the inputs for the new cycle and let them settle.
  task automatic go(input logic rdy, input logic [5:0] op, input logic z);
    @(posedge clk);
    #1;
    mem_ready = rdy;
    opcode    = op;
    zero      = z;
    #1;
  endtask

  initial begin
    rst = 1'b1; mem_ready = 1'b1; opcode = OP_R; zero = 1'b0;
    go(1'b1, OP_R, 1'b0);
    check("rst_state", state_out, 4'd0);
    check("rst_ir_write", ir_write, 1'b0);
    check("rst_pc_en", pc_en, 1'b0);
    check("rst_mem_read", mem_read, 1'b0);
    check("rst_timeout", mem_timeout, 1'b0);
    go(1'b1, OP_R, 1'b0);
    rst = 1'b0;
    #1;
    check("fetch_state", state_out, 4'd0);
    check("fetch_ir_write", ir_write, 1'b1);
    check("fetch_pc_en", pc_en, 1'b1);
    check("fetch_mem_read", mem_read, 1'b1);
    check("fetch_alu_b", alu_src_b, 2'b01);

    // R-type: 0,1,6,7,0
    go(1'b1, OP_R, 1'b0);
    check("r_decode_state", state_out, 4'd1);
    check("r_decode_alu_b", alu_src_b, 2'b11);
    check("r_decode_alu_op", alu_op, 3'b000);
    go(1'b1, OP_R, 1'b0);
    check("r_exec_state", state_out, 4'd6);
    check("r_exec_alu_op", alu_op, 3'b100);
    check("r_exec_alu_a", alu_src_a, 1'b1);
    check("r_exec_reg_write", reg_write, 1'b0);
    go(1'b1, OP_R, 1'b0);
    check("r_wb_state", state_out, 4'd7);
    check("r_wb_reg_write", reg_write, 1'b1);
    check("r_wb_reg_dst", reg_dst, 1'b1);
    check("r_wb_alu_op", alu_op, 3'b000);
    go(1'b1, OP_LW, 1'b0);
    check("r_back_fetch", state_out, 4'd0);
    $display("txn R-type complete");

    // lw with three stall cycles in MEM_RD
    go(1'b1, OP_LW, 1'b0);
    check("lw_decode", state_out, 4'd1);
    go(1'b0, OP_LW, 1'b0);
    check("lw_addr_state", state_out, 4'd2);
    check("lw_addr_alu_b", alu_src_b, 2'b10);
    check("lw_addr_alu_a", alu_src_a, 1'b1);
    for (int i = 0; i < 4; i++) begin
      go((i == 3) ? 1'b1 : 1'b0, OP_LW, 1'b0);
      check("lw_rd_state", state_out, 4'd3);
      check("lw_rd_mem_read", mem_read, 1'b1);
      check("lw_rd_i_or_d", i_or_d, 1'b1);
    end
    go(1'b1, OP_SW, 1'b0);
    check("lw_wb_state", state_out, 4'd4);
    check("lw_wb_mem_to_reg", mem_to_reg, 1'b1);
    check("lw_wb_reg_write", reg_write, 1'b1);
    check("lw_wb_reg_dst", reg_dst, 1'b0);
    go(1'b1, OP_SW, 1'b0);
    check("lw_back_fetch", state_out, 4'd0);
    $display("txn lw with 3 stalls complete");

    // sw
    go(1'b1, OP_SW, 1'b0);
    go(1'b1, OP_SW, 1'b0);
    check("sw_addr_state", state_out, 4'd2);
    go(1'b1, OP_SW, 1'b0);
    check("sw_wr_state", state_out, 4'd5);
    check("sw_wr_mem_write", mem_write, 1'b1);
    check("sw_wr_i_or_d", i_or_d, 1'b1);
    check("sw_wr_mem_read", mem_read, 1'b0);
    go(1'b1, OP_BEQ, 1'b1);
    check("sw_back_fetch", state_out, 4'd0);
    $display("txn sw complete");

    // beq taken then not taken
    for (int t = 0; t < 2; t++) begin
      go(1'b1, OP_BEQ, (t == 0));
      check("beq_decode", state_out, 4'd1);
      go(1'b1, OP_BEQ, (t == 0));
      check("beq_state", state_out, 4'd8);
      check("beq_alu_op", alu_op, 3'b001);
      check("beq_pc_src", pc_src, 2'b01);
      check("beq_pc_write_cond", pc_write_cond, 1'b1);
      check("beq_pc_en", pc_en, (t == 0) ? 1'b1 : 1'b0);
      go(1'b1, OP_J, 1'b0);
      check("beq_back_fetch", state_out, 4'd0);
      $display("txn beq zero=%0d complete", (t == 0));
    end

    // j
    go(1'b1, OP_J, 1'b0);
    go(1'b1, OP_J, 1'b0);
    check("j_state", state_out, 4'd9);
    check("j_pc_write", pc_write, 1'b1);
    check("j_pc_src", pc_src, 2'b10);
    check("j_pc_en", pc_en, 1'b1);
    go(1'b1, OP_ORI, 1'b0);
    check("j_back_fetch", state_out, 4'd0);
    $display("txn j complete");

    // I-type ALU ops: ori, slti, andi
    for (int k = 0; k < 3; k++) begin
      logic [5:0] op;
      logic [2:0] exp_op;
      op     = (k == 0) ? OP_ORI : (k == 1) ? OP_SLTI : OP_ANDI;
      exp_op = (k == 0) ? 3'b010 : (k == 1) ? 3'b111 : 3'b110;
      go(1'b1, op, 1'b0);
      check("i_decode", state_out, 4'd1);
      go(1'b1, op, 1'b0);
      check("i_exec_state", state_out, 4'd10);
      check("i_exec_alu_op", alu_op, exp_op);
      check("i_exec_alu_b", alu_src_b, 2'b10);
      check("i_exec_alu_a", alu_src_a, 1'b1);
      go(1'b1, op, 1'b0);
      check("i_wb_state", state_out, 4'd11);
      check("i_wb_reg_write", reg_write, 1'b1);
      check("i_wb_reg_dst", reg_dst, 1'b0);
      check("i_wb_mem_to_reg", mem_to_reg, 1'b0);
      go(1'b1, OP_BAD, 1'b0);
      check("i_back_fetch", state_out, 4'd0);
      $display("txn I-type opcode=%b complete", op);
    end

    // illegal opcode: one-cycle pulse in the FETCH that follows DECODE
    go(1'b1, OP_BAD, 1'b0);
    check("ill_decode", state_out, 4'd1);
    check("ill_before", illegal_op, 1'b0);
    go(1'b1, OP_R, 1'b0);
    check("ill_fetch_state", state_out, 4'd0);
    check("ill_pulse", illegal_op, 1'b1);
    check("ill_reg_write", reg_write, 1'b0);
    check("ill_mem_write", mem_write, 1'b0);
    go(1'b1, OP_R, 1'b0);
    check("ill_pulse_end", illegal_op, 1'b0);
    go(1'b1, OP_R, 1'b0);
    go(1'b1, OP_R, 1'b0);
    go(1'b0, OP_LW, 1'b0);
    check("ill_r_done_fetch", state_out, 4'd0);
    $display("txn illegal opcode complete");

    // FETCH watchdog: 16th stalled cycle (counter == 15) trips the timeout
    for (int i = 1; i <= 15; i++) begin
      check("wd_state", state_out, 4'd0);
      check("wd_ir_write", ir_write, 1'b0);
      check("wd_timeout_low", mem_timeout, 1'b0);
      go(1'b0, OP_LW, 1'b0);
    end
    check("wd_last_wait_timeout", mem_timeout, 1'b0);
    check("wd_last_wait_ir_write", ir_write, 1'b0);
    go(1'b1, OP_LW, 1'b0);
    check("wd_timeout_set", mem_timeout, 1'b1);
    check("wd_refetch_state", state_out, 4'd0);
    $display("txn fetch watchdog complete");

    // reset in the middle of lw while stalled in MEM_RD
    go(1'b1, OP_LW, 1'b0);
    go(1'b1, OP_LW, 1'b0);
    go(1'b0, OP_LW, 1'b0);
    check("rl_rd_state", state_out, 4'd3);
    check("rl_sticky", mem_timeout, 1'b1);
    rst = 1'b1;
    #1;
    check("rl_rst_mem_read", mem_read, 1'b0);
    check("rl_rst_i_or_d", i_or_d, 1'b0);
    check("rl_rst_pc_en", pc_en, 1'b0);
    go(1'b0, OP_LW, 1'b0);
    rst = 1'b0;
    #1;
    check("rl_state", state_out, 4'd0);
    check("rl_timeout_clear", mem_timeout, 1'b0);
    check("rl_reg_write", reg_write, 1'b0);
    $display("txn reset mid-lw complete");

    // mem_ready on the limit cycle wins over the timeout
    for (int i = 1; i <= 15; i++) go(1'b0, OP_R, 1'b0);
    mem_ready = 1'b1;
    #1;
    check("rw_ir_write", ir_write, 1'b1);
    go(1'b1, OP_R, 1'b0);
    check("rw_decode", state_out, 4'd1);
    check("rw_no_timeout", mem_timeout, 1'b0);
    $display("txn ready-on-limit complete");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
